// File: rtl/fma16_pkg.sv
// Shared widths and checker state type for the fma16 result checker.
package fma16_pkg;

  localparam int FLEN   = 16;
  localparam int NFLAGS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

endpackage

// File: rtl/fma16_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module fma16_sat_counter
  import fma16_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/fma16_result_checker.sv
// Compares fma16 results against expected values beat by beat and keeps run statistics.
// Optional build macro FMA16_FLAG_CHECK_EN: flag mismatches also count as errors.
module fma16_result_checker
  import fma16_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [FLEN-1:0]   result,
  input  logic [FLEN-1:0]   rexpected,
  input  logic [NFLAGS-1:0] flags,
  input  logic [NFLAGS-1:0] flagsexpected,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  err_index,
  output logic [FLEN-1:0]   err_result,
  output logic [FLEN-1:0]   err_expected
);

  chk_state_t state, state_nxt;

  logic accept_p0;
  logic mismatch_p0;
  logic vld_p0;
  logic err_inc_p0;
  logic first_err_p0;
  logic in_ready_nxt;
  logic done_nxt;
  logic pass_nxt;

`ifdef FMA16_FLAG_CHECK_EN
  assign mismatch_p0 = (result != rexpected) || (flags != flagsexpected);
`else
  assign mismatch_p0 = (result != rexpected);
  logic unused_flags;
  assign unused_flags = ^{flags, flagsexpected};
`endif

  // A start in the same cycle as a beat discards the beat.
  assign accept_p0    = in_valid && in_ready;
  assign vld_p0       = accept_p0 && !start;
  assign err_inc_p0   = vld_p0 && mismatch_p0;
  assign first_err_p0 = err_inc_p0 && (err_count == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      RUN:     if (vld_p0 && in_last) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = RUN;

    in_ready_nxt = (state_nxt == RUN);
    done_nxt     = (state_nxt == DONE);
    // pass must reflect the error count including the beat accepted this cycle.
    pass_nxt     = (state_nxt == DONE) && (err_count == '0) && !err_inc_p0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= in_ready_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
    end
  end

  // ---- p0 -> p1: statistics update ----
  fma16_sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .inc     (vld_p0),
    .count   (vec_count)
  );

  fma16_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .inc     (err_inc_p0),
    .count   (err_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_index    <= '0;
      err_result   <= '0;
      err_expected <= '0;
    end else if (start) begin
      err_index    <= '0;
      err_result   <= '0;
      err_expected <= '0;
    end else if (first_err_p0) begin
      err_index    <= vec_count;
      err_result   <= result;
      err_expected <= rexpected;
    end
  end

endmodule

// File: tb/tb_fma16_result_checker.sv
// Scoreboard bench: runs are described as beat lists, expected statistics come from a list-level model.
module tb_fma16_result_checker;

  typedef struct {
    logic [15:0] r;
    logic [15:0] e;
    logic [3:0]  f;
    logic [3:0]  fe;
  } beat_t;

  typedef struct {
    logic [31:0] vec32;
    logic [31:0] err32;
    logic [31:0] idx32;
    logic [3:0]  vec4;
    logic [3:0]  err4;
    logic [3:0]  idx4;
    logic [15:0] res;
    logic [15:0] exp;
    logic        pass;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [15:0] result = '0;
  logic [15:0] rexpected = '0;
  logic [3:0]  flags = '0;
  logic [3:0]  flagsexpected = '0;

  logic        a_ready, a_done, a_pass;
  logic [31:0] a_vec, a_err, a_idx;
  logic [15:0] a_res, a_exp;
  logic        b_ready, b_done, b_pass;
  logic [3:0]  b_vec, b_err, b_idx;
  logic [15:0] b_res, b_exp;

  int n_tests = 0;
  int n_fail  = 0;
  beat_t beats[$];
  exp_t  expq[$];

  always #5 clk = ~clk;

  fma16_result_checker #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .in_last(in_last), .result(result), .rexpected(rexpected), .flags(flags),
    .flagsexpected(flagsexpected), .done(a_done), .pass(a_pass), .vec_count(a_vec),
    .err_count(a_err), .err_index(a_idx), .err_result(a_res), .err_expected(a_exp)
  );

  fma16_result_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .in_last(in_last), .result(result), .rexpected(rexpected), .flags(flags),
    .flagsexpected(flagsexpected), .done(b_done), .pass(b_pass), .vec_count(b_vec),
    .err_count(b_err), .err_index(b_idx), .err_result(b_res), .err_expected(b_exp)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic bit is_mismatch(input beat_t b);
`ifdef FMA16_FLAG_CHECK_EN
    return (b.r != b.e) || (b.f != b.fe);
`else
    return b.r != b.e;
`endif
  endfunction

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  task automatic add_beat(input logic [15:0] r, input logic [15:0] e,
                          input logic [3:0] f, input logic [3:0] fe);
    beat_t b;
    b.r = r; b.e = e; b.f = f; b.fe = fe;
    beats.push_back(b);
  endtask

  task automatic add_random_beats(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] r, e;
      logic [3:0]  f, fe;
      r  = 16'($urandom);
      e  = ($urandom_range(0, 9) < 3) ? (r ^ (16'h1 << $urandom_range(0, 15))) : r;
      f  = 4'($urandom);
      fe = ($urandom_range(0, 9) < 2) ? ~f : f;
      add_beat(r, e, f, fe);
    end
  endtask

  task automatic drive_beat(input beat_t b, input logic last);
    @(negedge clk);
    in_valid = 1'b1; in_last = last;
    result = b.r; rexpected = b.e; flags = b.f; flagsexpected = b.fe;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_vec", a_vec, 0);
    chk("start_err", a_err, 0);
    chk("start_done", a_done, 0);
    chk("start_ready", a_ready, 1);
  endtask

  // Model: the run's statistics follow from the beat list alone.
  task automatic send_beats(input bit gaps);
    exp_t x;
    int n, k, first;
    n = beats.size(); k = 0; first = -1;
    for (int i = 0; i < n; i++) begin
      if (is_mismatch(beats[i])) begin
        if (first < 0) first = i;
        k++;
      end
    end
    x.vec32 = n; x.err32 = k; x.idx32 = (first < 0) ? 0 : first;
    x.vec4 = sat4(n); x.err4 = sat4(k); x.idx4 = (first < 0) ? 4'h0 : sat4(first);
    x.res = (first < 0) ? 16'h0 : beats[first].r;
    x.exp = (first < 0) ? 16'h0 : beats[first].e;
    x.pass = (k == 0);
    expq.push_back(x);
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'($urandom);
        result = 16'($urandom); rexpected = ~result;
      end
      drive_beat(beats[i], i == n - 1);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    beats.delete();
  endtask

  // Monitor: checks statistics whenever a run reports done.
  initial begin
    logic dprev;
    exp_t x;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      if (a_done && !dprev) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          x = expq.pop_front();
          chk("vec_count", a_vec, x.vec32);
          chk("err_count", a_err, x.err32);
          chk("err_index", a_idx, x.idx32);
          chk("err_result", a_res, x.res);
          chk("err_expected", a_exp, x.exp);
          chk("pass", a_pass, x.pass);
          chk("done_ready", a_ready, 0);
          chk("w4_done", b_done, 1);
          chk("w4_vec_count", b_vec, x.vec4);
          chk("w4_err_count", b_err, x.err4);
          chk("w4_err_index", b_idx, x.idx4);
          chk("w4_err_result", b_res, x.res);
          chk("w4_pass", b_pass, x.pass);
        end
      end
      dprev = a_done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_ready", a_ready, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_vec", a_vec, 0);
    chk("rst_err", a_err, 0);
    chk("rst_idx", a_idx, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", a_ready, 0);

    // Three matching beats
    do_start();
    for (int i = 0; i < 3; i++) add_beat(16'h3C00, 16'h3C00, 4'h0, 4'h0);
    send_beats(1'b0);
    in_valid = 1'b1; result = 16'h1111; rexpected = 16'h2222; in_last = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("done_ignores_vec", a_vec, 3);
    chk("done_ignores_err", a_err, 0);
    chk("done_hold", a_done, 1);
    chk("done_pass", a_pass, 1);

    // Two mismatches, first at index 2
    do_start();
    add_beat(16'h3C00, 16'h3C00, 4'h0, 4'h0);
    add_beat(16'h4000, 16'h4000, 4'h0, 4'h0);
    add_beat(16'h3C01, 16'h3C00, 4'h0, 4'h0);
    add_beat(16'h4200, 16'h4200, 4'h0, 4'h0);
    add_beat(16'h0000, 16'h8000, 4'h0, 4'h0);
    send_beats(1'b0);

    // Flag-only difference
    do_start();
    add_beat(16'h3C00, 16'h3C00, 4'h1, 4'h0);
    send_beats(1'b0);

    // Start collides with a mismatching beat
    do_start();
    begin
      beat_t b;
      b.r = 16'h1234; b.e = 16'h4321; b.f = 0; b.fe = 0;
      drive_beat(b, 1'b0);
      b.r = 16'h5555; b.e = 16'h5555;
      drive_beat(b, 1'b0);
    end
    @(negedge clk);
    chk("pre_restart_vec", a_vec, 2);
    start = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    result = 16'hABCD; rexpected = 16'h0000;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("collide_vec", a_vec, 0);
    chk("collide_err", a_err, 0);
    chk("collide_idx", a_idx, 0);
    chk("collide_res", a_res, 0);
    chk("collide_done", a_done, 0);
    add_beat(16'h3800, 16'h3800, 4'h0, 4'h0);
    add_beat(16'h3A00, 16'h3A00, 4'h0, 4'h0);
    send_beats(1'b0);

    // Twenty mismatches saturate the narrow instance
    do_start();
    for (int i = 0; i < 20; i++) add_beat(16'(i + 1), 16'hFFFF, 4'h0, 4'h0);
    send_beats(1'b0);

    // Random runs with idle gaps
    for (int run = 0; run < 10; run++) begin
      do_start();
      add_random_beats($urandom_range(1, 25));
      send_beats(1'b1);
    end

    // Asynchronous reset between edges in the middle of a run
    do_start();
    begin
      beat_t b;
      b.r = 16'h0001; b.e = 16'h0001; b.f = 0; b.fe = 0;
      drive_beat(b, 1'b0);
      b.r = 16'h7C00; b.e = 16'h7E00;
      drive_beat(b, 1'b0);
      drive_beat(b, 1'b0);
    end
    @(posedge clk);
    #2;
    chk("pre_reset_err", a_err, 2);
    reset_n = 1'b0;
    #1;
    chk("areset_vec", a_vec, 0);
    chk("areset_err", a_err, 0);
    chk("areset_idx", a_idx, 0);
    chk("areset_res", a_res, 0);
    chk("areset_exp", a_exp, 0);
    chk("areset_ready", a_ready, 0);
    chk("areset_done", a_done, 0);
    chk("areset_w4_vec", b_vec, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_ready", a_ready, 0);
    chk("post_reset_vec", a_vec, 0);
    in_valid = 1'b0;

    do_start();
    add_random_beats(6);
    send_beats(1'b1);

    for (int i = 0; i < 50 && expq.size() != 0; i++) @(negedge clk);
    if (expq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d runs without done, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
